// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver with a divisor-driven oversample tick; rx_valid rises ~(8+8*16+16)*(D+1)+3 cycles after the start edge.
// Byte held under valid/ack; no backpressure on the line, so a completed frame with an unacked byte is dropped and flagged as overrun.
module uart_rx_oversampled #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 m_clk,
    input  logic                 reset,
    input  logic [7:0]           divisor_1,
    input  logic [7:0]           divisor_2,
    input  logic                 rx_serial,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 framing_err,
    output logic                 overrun_err
);

    localparam int HALF = OVERSAMPLE / 2;
    localparam int SW   = $clog2(OVERSAMPLE);
    localparam int BW   = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        STOP       = 3'd3,
        BREAK_WAIT = 3'd4
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 rx_meta;
    logic                 rxs;
    logic [15:0]          d_lat;
    logic [15:0]          tick_cnt;
    logic [SW-1:0]        samp_cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;

    logic tick;
    logic half_pt;
    logic full_pt;
    logic last_bit;
    logic shift_en;
    logic frame_done;
    logic frame_bad;

    assign tick     = (state != IDLE) && (tick_cnt == d_lat);
    assign half_pt  = tick && (samp_cnt == SW'(HALF - 1));
    assign full_pt  = tick && (samp_cnt == SW'(OVERSAMPLE - 1));
    assign last_bit = (bit_idx == BW'(DATA_BITS - 1));

    always_ff @(posedge m_clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx_serial;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge m_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (!rxs) state_nxt = START;
            START:      if (half_pt) state_nxt = rxs ? IDLE : DATA;
            DATA:       if (full_pt && last_bit) state_nxt = STOP;
            STOP:       if (full_pt) state_nxt = rxs ? IDLE : BREAK_WAIT;
            BREAK_WAIT: if (rxs) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        shift_en   = 1'b0;
        frame_done = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            DATA: shift_en = full_pt;
            STOP: begin
                frame_done = full_pt && rxs;
                frame_bad  = full_pt && !rxs;
            end
            default: ;
        endcase
    end

    always_ff @(posedge m_clk) begin
        if (reset) begin
            d_lat       <= '0;
            tick_cnt    <= '0;
            samp_cnt    <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_busy     <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (state == IDLE) begin
                tick_cnt <= '0;
                samp_cnt <= '0;
                bit_idx  <= '0;
                if (!rxs) d_lat <= {divisor_2, divisor_1};
            end else begin
                tick_cnt <= tick ? 16'd0 : tick_cnt + 16'd1;
                // START ends its bit at mid-point so DATA samples land mid-bit
                if (tick) begin
                    if ((state == START) ? half_pt : full_pt) samp_cnt <= '0;
                    else samp_cnt <= samp_cnt + 1'b1;
                end
                if (shift_en) begin
                    shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                    bit_idx <= bit_idx + 1'b1;
                end
            end

            framing_err <= frame_bad;
            overrun_err <= frame_done && rx_valid && !rx_ack;
            if (frame_done && (!rx_valid || rx_ack)) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ack) begin
                rx_valid <= 1'b0;
            end
            rx_busy <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: tick-index reference model compared every cycle, plus directed literal checks.
module tb_uart_rx_oversampled;

    localparam int OS     = 16;
    localparam int DB     = 8;
    localparam int HALF   = OS / 2;
    localparam int STOP_T = HALF + (DB + 1) * OS;

    logic       m_clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] divisor_1 = 8'd0;
    logic [7:0] divisor_2 = 8'd0;
    logic       rx_serial = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       framing_err;
    logic       overrun_err;

    always #5 m_clk = ~m_clk;

    uart_rx_oversampled #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .m_clk(m_clk),
        .reset(reset),
        .divisor_1(divisor_1),
        .divisor_2(divisor_2),
        .rx_serial(rx_serial),
        .rx_ack(rx_ack),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_busy(rx_busy),
        .framing_err(framing_err),
        .overrun_err(overrun_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: frame sample points expressed as tick indices after start detection.
    int         cyc = 0;
    logic       p1 = 1'b1, p2 = 1'b1;
    int         mmode = 0;
    int         e0 = 0, dl = 0, mk = 0, mt = 0;
    logic       mrs = 1'b1, mdone = 1'b0, mbad = 1'b0;
    logic [7:0] mbits = 8'd0;
    logic       m_valid = 1'b0, m_busy = 1'b0, m_fe = 1'b0, m_ov = 1'b0;
    logic [7:0] m_data = 8'd0;
    bit         model_ready = 1'b0;

    always @(posedge m_clk) begin
        cyc++;
        mrs   = p2;
        mdone = 1'b0;
        mbad  = 1'b0;
        m_fe  = 1'b0;
        m_ov  = 1'b0;
        if (reset) begin
            p1 = 1'b1; p2 = 1'b1; mmode = 0; mbits = 8'd0;
            m_valid = 1'b0; m_data = 8'd0; m_busy = 1'b0;
            model_ready = 1'b1;
        end else begin
            p2 = p1;
            p1 = rx_serial;
            case (mmode)
                0: if (!mrs) begin
                    mmode = 1; e0 = cyc; dl = int'({divisor_2, divisor_1});
                end
                1: begin
                    mk = cyc - e0;
                    if (mk % (dl + 1) == 0) begin
                        mt = mk / (dl + 1);
                        if (mt == HALF) begin
                            if (mrs) mmode = 0;
                        end else if (mt > HALF && mt < STOP_T && (mt - HALF) % OS == 0) begin
                            mbits[(mt - HALF) / OS - 1] = mrs;
                        end else if (mt == STOP_T) begin
                            if (mrs) begin mdone = 1'b1; mmode = 0; end
                            else begin mbad = 1'b1; mmode = 2; end
                        end
                    end
                end
                default: if (mrs) mmode = 0;
            endcase
            m_fe = mbad;
            if (mdone) begin
                if (!m_valid || rx_ack) begin m_data = mbits; m_valid = 1'b1; end
                else m_ov = 1'b1;
            end else if (m_valid && rx_ack) begin
                m_valid = 1'b0;
            end
            m_busy = (mmode != 0);
        end
    end

    int         n_vrise = 0, n_fe = 0, n_ov = 0, n_brise = 0, v_rise_cyc = 0;
    logic       pv = 1'b0, pb = 1'b0;
    logic [7:0] rxq[$];

    always @(negedge m_clk) begin
        if (model_ready) begin
            chk("rx_valid", 32'(rx_valid), 32'(m_valid));
            chk("rx_data", 32'(rx_data), 32'(m_data));
            chk("rx_busy", 32'(rx_busy), 32'(m_busy));
            chk("framing_err", 32'(framing_err), 32'(m_fe));
            chk("overrun_err", 32'(overrun_err), 32'(m_ov));
            if (rx_valid === 1'b1 && !pv) begin
                n_vrise++; v_rise_cyc = cyc; rxq.push_back(rx_data);
            end
            if (rx_busy === 1'b1 && !pb) n_brise++;
            if (framing_err === 1'b1) n_fe++;
            if (overrun_err === 1'b1) n_ov++;
            pv = (rx_valid === 1'b1);
            pb = (rx_busy === 1'b1);
        end
    end

    bit auto_ack = 1'b0, ack_exact = 1'b0;
    int ack_dly = 3, wait_cnt = 0;

    initial forever begin
        @(posedge m_clk); #2;
        if (rx_ack) rx_ack = 1'b0;
        else if (ack_exact && mmode == 1 && (cyc + 1 - e0) == STOP_T * (dl + 1)) rx_ack = 1'b1;
        else if (auto_ack && rx_valid) begin
            if (wait_cnt >= ack_dly) begin
                rx_ack = 1'b1; wait_cnt = 0; ack_dly = $urandom_range(0, 9);
            end else wait_cnt++;
        end
    end

    task automatic cyc_wait(input int n);
        repeat (n) begin @(posedge m_clk); #2; end
    endtask

    task automatic set_div(input int d);
        {divisor_2, divisor_1} = 16'(d);
    endtask

    task automatic send(input logic [7:0] b, input bit stop_ok, input int cpb, input bit scramble);
        rx_serial = 1'b0;
        cyc_wait(cpb);
        if (scramble) {divisor_2, divisor_1} = 16'($urandom);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            cyc_wait(cpb);
        end
        rx_serial = stop_ok;
        cyc_wait(cpb);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_data"}, 32'(rx_data), 32'h0);
        chk({tag, "_valid"}, 32'(rx_valid), 32'h0);
        chk({tag, "_busy"}, 32'(rx_busy), 32'h0);
        chk({tag, "_ferr"}, 32'(framing_err), 32'h0);
        chk({tag, "_oerr"}, 32'(overrun_err), 32'h0);
    endtask

    int fall_cyc, lat, b0, v0, f0, o0, d, gap;
    logic [7:0] rb;
    bit bad;

    initial begin
        reset = 1'b1;
        cyc_wait(3);
        @(negedge m_clk);
        chk_reset_vals("reset");
        cyc_wait(1);
        reset = 1'b0;
        cyc_wait(10);

        // 0xA5 at D=0, latency window
        set_div(0);
        fall_cyc = cyc;
        send(8'hA5, 1'b1, 16, 1'b0);
        lat = v_rise_cyc - fall_cyc;
        chk("latency_153_156", 32'(lat >= 153 && lat <= 156), 32'h1);
        chk("a5_data", 32'(rx_data), 32'hA5);
        chk("a5_valid_held", 32'(rx_valid), 32'h1);
        chk("a5_ferr_count", 32'(n_fe), 32'h0);
        auto_ack = 1'b1;
        cyc_wait(20);
        chk("a5_acked", 32'(rx_valid), 32'h0);

        // 0x00 then 0xFF back-to-back at D=3
        set_div(3);
        rxq.delete();
        b0 = n_brise; f0 = n_fe; o0 = n_ov;
        send(8'h00, 1'b1, 64, 1'b0);
        send(8'hFF, 1'b1, 64, 1'b0);
        cyc_wait(40);
        chk("b2b_count", 32'(rxq.size()), 32'h2);
        chk("b2b_first", 32'(rxq.size() > 0 ? rxq[0] : 8'hxx), 32'h00);
        chk("b2b_second", 32'(rxq.size() > 1 ? rxq[1] : 8'hxx), 32'hFF);
        chk("b2b_busy_gap", 32'(n_brise - b0), 32'h2);
        chk("b2b_no_err", 32'(n_fe - f0 + n_ov - o0), 32'h0);

        // 4-cycle glitch
        set_div(0);
        b0 = n_brise; v0 = n_vrise; f0 = n_fe;
        rx_serial = 1'b0; cyc_wait(4); rx_serial = 1'b1;
        cyc_wait(30);
        chk("glitch_started", 32'(n_brise - b0), 32'h1);
        chk("glitch_idle", 32'(rx_busy), 32'h0);
        chk("glitch_no_valid", 32'(n_vrise - v0), 32'h0);
        chk("glitch_no_ferr", 32'(n_fe - f0), 32'h0);

        // framing error and held break
        v0 = n_vrise; f0 = n_fe;
        send(8'h3C, 1'b0, 16, 1'b0);
        cyc_wait(200);
        chk("break_busy", 32'(rx_busy), 32'h1);
        chk("break_ferr_once", 32'(n_fe - f0), 32'h1);
        chk("break_data_kept", 32'(rx_data), 32'hFF);
        chk("break_no_valid", 32'(n_vrise - v0), 32'h0);
        rx_serial = 1'b1;
        cyc_wait(10);
        chk("break_release", 32'(rx_busy), 32'h0);
        send(8'h55, 1'b1, 16, 1'b0);
        cyc_wait(20);
        chk("after_break_55", 32'(rxq[$]), 32'h55);

        // overrun, then ack in the completion cycle
        auto_ack = 1'b0;
        cyc_wait(5);
        o0 = n_ov;
        send(8'h11, 1'b1, 16, 1'b0);
        send(8'h22, 1'b1, 16, 1'b0);
        cyc_wait(10);
        chk("ovr_pulse_once", 32'(n_ov - o0), 32'h1);
        chk("ovr_data_kept", 32'(rx_data), 32'h11);
        chk("ovr_valid", 32'(rx_valid), 32'h1);
        auto_ack = 1'b1; cyc_wait(15); auto_ack = 1'b0;
        chk("ovr_cleared", 32'(rx_valid), 32'h0);
        send(8'h11, 1'b1, 16, 1'b0);
        cyc_wait(5);
        chk("same_cyc_first", 32'(rx_data), 32'h11);
        o0 = n_ov;
        ack_exact = 1'b1;
        send(8'h22, 1'b1, 16, 1'b0);
        cyc_wait(5);
        ack_exact = 1'b0;
        chk("same_cyc_data", 32'(rx_data), 32'h22);
        chk("same_cyc_valid", 32'(rx_valid), 32'h1);
        chk("same_cyc_no_ovr", 32'(n_ov - o0), 32'h0);
        auto_ack = 1'b1;
        cyc_wait(15);

        // reset in the middle of data bit 4
        rb = 8'h7E;
        rx_serial = 1'b0; cyc_wait(16);
        for (int i = 0; i < 4; i++) begin rx_serial = rb[i]; cyc_wait(16); end
        rx_serial = rb[4]; cyc_wait(8);
        reset = 1'b1; rx_serial = 1'b1;
        cyc_wait(1);
        @(negedge m_clk);
        chk_reset_vals("midreset");
        cyc_wait(1);
        reset = 1'b0;
        v0 = n_vrise;
        cyc_wait(20);
        chk("midreset_no_output", 32'(n_vrise - v0), 32'h0);
        send(8'h7E, 1'b1, 16, 1'b0);
        cyc_wait(20);
        chk("midreset_7e", 32'(rxq[$]), 32'h7E);

        // randomized frames against the model
        for (int n = 0; n < 12; n++) begin
            d = $urandom_range(0, 2);
            set_div(d);
            rb = 8'($urandom);
            bad = ($urandom_range(0, 5) == 0);
            auto_ack = ($urandom_range(0, 3) != 0);
            send(rb, !bad, (d + 1) * OS, 1'($urandom_range(0, 1)));
            if (bad) begin
                cyc_wait($urandom_range(10, 60));
                rx_serial = 1'b1;
            end
            gap = $urandom_range(0, 40);
            cyc_wait(gap);
        end
        auto_ack = 1'b1;
        cyc_wait(100);
        chk("final_drained", 32'(rx_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog expired t=%0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
- UART receiver: the serial-in counterpart to the team's baud-rate generator and transmitter.
- Runs on m_clk with an internal oversample tick built from the same {divisor_2, divisor_1} 16-bit divisor registers.
- Deserialises 8N1 frames (start, DATA_BITS LSB-first, 1 stop) into a parallel byte, held under a valid/ack handshake, and flags framing and overrun errors.

Parameters:
- OVERSAMPLE, 16, ticks per bit period; mid-bit sample point is OVERSAMPLE/2; must be even and ≥4.
- DATA_BITS, 8, data bits per frame.

Ports:
- m_clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- divisor_1  in  8  divisor low byte.
- divisor_2  in  8  divisor high byte.
- rx_serial  in  1  asynchronous serial line; idle high.
- rx_ack  in  1  consumer has taken rx_data.
- rx_data  out  DATA_BITS  last received byte.
- rx_valid  out  1  rx_data holds an unacknowledged byte.
- rx_busy  out  1  a frame is in progress (state ≠ IDLE).
- framing_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun_err  out  1  one-cycle pulse: frame completed while rx_valid=1 and no ack.

Behaviour:

Reset (synchronous, active-high)
- Takes priority over all other activity, including mid-frame. The partial frame is discarded.
- Reset values:
  - state=IDLE
  - sync flops=1
  - tick counter=0, sample counter=0, bit index=0, shift register=0
  - rx_data=0, rx_valid=0, rx_busy=0, framing_err=0, overrun_err=0

Input path and ticks
- rx_serial passes through a 2-flop synchroniser (rxs); all decisions use rxs.
- Divisor D={divisor_2,divisor_1} is latched on start detection and held for the whole frame. Changes mid-frame have no effect until the next frame.
- Tick counter runs only when state≠IDLE. tick=1 in the cycle the counter equals D_latched; the counter then clears. So one tick every D+1 cycles (D=0 gives a tick every cycle).
- Sample counter counts ticks within the current bit.

State machine
- IDLE: when rxs=0, latch D, clear counters → START.
- START: on the (OVERSAMPLE/2)th tick, sample rxs.
  - rxs=0: clear counters → DATA.
  - rxs=1 (glitch): → IDLE, no error flagged.
- DATA: on every OVERSAMPLE-th tick, shift rxs into the MSB of the shift register (data is LSB-first). After DATA_BITS samples → STOP.
- STOP: on the OVERSAMPLE-th tick, sample rxs.
  - rxs=1: load rx_data and set rx_valid → IDLE.
  - rxs=0: pulse framing_err; data discarded, rx_data unchanged → BREAK_WAIT.
- BREAK_WAIT: stay until rxs=1 → IDLE. This prevents a held-low break from retriggering as a new start.

Output timing
- All outputs are registered and update on the edge that processes the tick.
- rx_busy=1 in START, DATA, STOP, BREAK_WAIT.

Handshake and overrun
- rx_valid stays high until a cycle with rx_valid=1 and rx_ack=1; it clears on that edge.
- rx_ack while rx_valid=0 is ignored.
- Frame completes while rx_valid=1 and rx_ack=0: pulse overrun_err. The old rx_data is kept, the new byte is dropped, rx_valid stays 1.
- Frame completes in the same cycle as rx_ack: the new byte loads, rx_valid stays 1, no overrun.

Latency
- With D=0 and OVERSAMPLE=16, rx_valid rises 153–156 m_clk cycles after the rx_serial falling edge: 2–3 cycles of sync/detect, 8+8×16+16 ticks, plus 1 register stage.

Test Plan:
- D=0, send 0xA5 (8N1, 16 cycles/bit), rx_ack=0 → rx_valid rises 153–156 cycles after the start edge, rx_data=0xA5, framing_err=0.
- D=0x0003 (64 cycles/bit), send 0x00 then 0xFF back-to-back, ack each within 10 cycles of rx_valid → rx_data 0x00 then 0xFF, no errors; rx_busy low for ≥1 cycle between frames.
- Low pulse of 4 cycles on an idle line, D=0 → START aborts at mid-bit, rx_busy returns to 0, no rx_valid, no framing_err.
- D=0, send 0x3C with stop bit forced low, hold line low 200 cycles then release → one framing_err pulse, rx_data unchanged; no new START until the line is high; a following 0x55 frame is received correctly.
- D=0, send 0x11 (no ack), then 0x22 → overrun_err pulses once, rx_data stays 0x11, rx_valid=1. Repeat with rx_ack asserted exactly in the 0x22 completion cycle → rx_data=0x22, no overrun.
- Assert reset during DATA bit 4 of a frame, release, send 0x7E → all outputs at reset values after the reset edge; the partial frame produces no output; 0x7E is received correctly.
